mult_div_unit: RTL and testbench

- Iterative multiply/divide unit consumed by the multicycle control unit for MIPS mult, multu, div and divu.
- Sits beside the ALU in the datapath. Takes operands from the A/B registers and holds the 64-bit result in the Hi/Lo registers.
- Uses a start/busy/done handshake. The control unit starts an operation and waits in a stall state until Done.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_core.sv | 58 +++++
 rtl/mult_div_unit.sv | 156 +++++++++++++++
 tb/tb_mult_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
//   state_t : sequencing states of the iterative unit
//   op_t    : operation latched at the start edge
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    // One iteration per operand bit.
    localparam int MDU_ITER  = MDU_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

endpackage

// File: rtl/mdu_core.sv
// One iteration step of the multiply/divide unit, purely combinational.
//   op      : OP_MUL = shift-add step, OP_DIV = restoring-divide step
//   acc_hi  : upper accumulator (product high word / remainder), WIDTH+1 bits
//   acc_lo  : lower accumulator (product low word / quotient)
//   operand : multiplicand magnitude (mul) or divisor magnitude (div)
//   bit_in  : current multiplier bit (LSB first) or dividend bit (MSB first)
//   next_hi : accumulator upper part after this step
//   next_lo : accumulator lower part after this step
import mdu_pkg::*;

module mdu_core #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  op_t              op,
    input  logic [WIDTH:0]   acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    input  logic             bit_in,
    output logic [WIDTH:0]   next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        sum     = '0;
        shifted = '0;
        trial   = '0;
        next_hi = acc_hi;
        next_lo = acc_lo;

        if (op == OP_MUL) begin
            // The upper bit of acc_hi is always zero in multiply mode, so the
            // WIDTH+1 bit sum holds the carry out of the partial-product add.
            sum     = acc_hi + (bit_in ? {1'b0, operand} : '0);
            // Shift the whole partial product right by one.
            next_hi = {1'b0, sum[WIDTH:1]};
            next_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            // The remainder is always below the divisor, so after the shift it
            // fits in WIDTH+1 bits and the trial result's top bit is its sign.
            shifted = {acc_hi[WIDTH-1:0], bit_in};
            trial   = shifted - {1'b0, operand};
            if (!trial[WIDTH]) begin
                next_hi = trial;
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted;
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for mult, multu, div and divu.
//   Clk      : clock, all state updates on the rising edge
//   Reset    : synchronous active-high reset
//   MulStart : start a multiply (sampled in IDLE, wins over DivStart)
//   DivStart : start a divide (sampled in IDLE)
//   Unsigned : 1 = unsigned operation, sampled with the start
//   A, B     : multiplicand/multiplier or dividend/divisor
//   Busy     : high whenever the unit is not IDLE
//   Done     : one-cycle pulse, Hi/Lo valid from this cycle on
//   DivZero  : pulses with Done when a divide had B == 0
//   Hi, Lo   : product high/low word, or remainder/quotient
import mdu_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             MulStart,
    input  logic             DivStart,
    input  logic             Unsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, next_state;
    op_t              op;
    logic [CW-1:0]    count;
    logic             neg_lo;     // sign of product / quotient
    logic             neg_hi;     // sign of remainder
    logic             div_zero;
    logic [WIDTH-1:0] opa;        // multiplicand, or dividend shifted out MSB first
    logic [WIDTH-1:0] opb;        // multiplier shifted out LSB first, or divisor
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             start;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero;
    logic [WIDTH:0]   core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign start  = MulStart | DivStart;
    assign b_zero = (B == '0);

    // Magnitudes for signed operands; 0x80..0 negates to itself, which the
    // unsigned iteration treats correctly as 2**(WIDTH-1).
    assign a_neg = ~Unsigned & A[WIDTH-1];
    assign b_neg = ~Unsigned & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .op      (op),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand ((op == OP_MUL) ? opa : opb),
        .bit_in  ((op == OP_MUL) ? opb[0] : opa[WIDTH-1]),
        .next_hi (core_hi),
        .next_lo (core_lo)
    );

    // Sign correction: the product is negated as one 2*WIDTH value, the
    // quotient and remainder independently.
    assign product     = {acc_hi[WIDTH-1:0], acc_lo};
    assign product_fix = neg_lo ? -product : product;
    assign quot_fix    = neg_lo ? -acc_lo : acc_lo;
    assign rem_fix     = neg_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) begin
                // A divide by zero skips the iterations entirely.
                next_state = (!MulStart && b_zero) ? DONE : CALC;
            end
            CALC: if (count == CW'(WIDTH-1)) next_state = SIGN;
            SIGN: next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every register, Hi/Lo included, is cleared on reset so an aborted
    // operation leaves no partial result visible.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op       <= OP_MUL;
            count    <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    op       <= MulStart ? OP_MUL : OP_DIV;
                    opa      <= a_mag;
                    opb      <= b_mag;
                    neg_lo   <= a_neg ^ b_neg;
                    neg_hi   <= MulStart ? 1'b0 : a_neg;
                    div_zero <= !MulStart && b_zero;
                    count    <= '0;
                    acc_hi   <= '0;
                    acc_lo   <= '0;
                end
                CALC: begin
                    acc_hi <= core_hi;
                    acc_lo <= core_lo;
                    count  <= count + 1'b1;
                    if (op == OP_MUL) opb <= opb >> 1;
                    else              opa <= opa << 1;
                end
                SIGN: begin
                    if (op == OP_MUL) begin
                        Hi <= product_fix[2*WIDTH-1:WIDTH];
                        Lo <= product_fix[WIDTH-1:0];
                    end else begin
                        Hi <= rem_fix;
                        Lo <= quot_fix;
                    end
                end
                DONE: div_zero <= 1'b0;
                default: ;
            endcase
        end
    end

    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);
    assign DivZero = (state == DONE) && div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         MulStart, DivStart, Unsigned;
    logic [W-1:0] A, B;
    logic         Busy, Done, DivZero;
    logic [W-1:0] Hi, Lo;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MulStart (MulStart),
        .DivStart (DivStart),
        .Unsigned (Unsigned),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .DivZero  (DivZero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: MIPS semantics from ordinary integer arithmetic.
    task automatic model(input bit is_mul, input bit uns, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] hi,
                         output logic [W-1:0] lo, output bit dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        dz = 1'b0;
        if (is_mul) begin
            if (uns) p = {32'b0, a} * {32'b0, b};
            else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            dz = 1'b1;
            hi = model_hi;
            lo = model_lo;
        end else if (uns) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    // Issue one operation, optionally pulse a stray DivStart on sample
    // 'inject' while busy, and check latency, flags and result.
    task automatic run_op(input string tag, input bit mul, input bit div, input bit uns,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
        logic [W-1:0] exp_hi, exp_lo;
        bit           exp_dz;
        int           n;
        model(mul, uns, a, b, exp_hi, exp_lo, exp_dz);

        @(negedge Clk);
        MulStart = mul; DivStart = div; Unsigned = uns; A = a; B = b;
        @(negedge Clk);
        MulStart = 0; DivStart = 0; Unsigned = $urandom_range(1); A = $urandom; B = $urandom;
        n = 1;
        while (Done !== 1'b1 && n < 100) begin
            DivStart = (n == inject);
            if (n == inject) B = '0;
            @(negedge Clk);
            n++;
        end
        DivStart = 0;

        // Count of rising edges from the start edge through the one raising Done.
        check({tag, ".latency"}, 64'(n), exp_dz ? 64'd1 : 64'd34);
        check({tag, ".busy_in_done"}, 64'(Busy), 64'd1);
        check({tag, ".divzero"}, 64'(DivZero), 64'(exp_dz));
        check({tag, ".hi"}, 64'(Hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(Lo), 64'(exp_lo));
        @(negedge Clk);
        check({tag, ".done_pulse"}, 64'(Done), 64'd0);
        check({tag, ".idle_after"}, 64'(Busy), 64'd0);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    task automatic reset_mid_op();
        int dones;
        @(negedge Clk);
        MulStart = 1; Unsigned = 0; A = 32'h1234_5678; B = 32'h0000_9ABC;
        @(negedge Clk);
        MulStart = 0;
        repeat (10) @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        Reset = 0;
        check("rst_mid.busy", 64'(Busy), 64'd0);
        check("rst_mid.done", 64'(Done), 64'd0);
        check("rst_mid.hi", 64'(Hi), 64'd0);
        check("rst_mid.lo", 64'(Lo), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("rst_mid.no_done", 64'(dones), 64'd0);
        model_hi = '0;
        model_lo = '0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           rmul, runs;
        Reset = 1; MulStart = 0; DivStart = 0; Unsigned = 0; A = '0; B = '0;
        repeat (3) @(negedge Clk);
        check("reset.busy", 64'(Busy), 64'd0);
        check("reset.done", 64'(Done), 64'd0);
        check("reset.divzero", 64'(DivZero), 64'd0);
        check("reset.hi", 64'(Hi), 64'd0);
        check("reset.lo", 64'(Lo), 64'd0);
        Reset = 0;

        run_op("mul_signed",   1, 0, 0, 32'd7,          32'hFFFF_FFFD, 0);
        run_op("mul_unsigned", 1, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
        run_op("div_signed",   0, 1, 0, 32'hFFFF_FFF9,  32'd2,         0);
        run_op("preload",      1, 0, 1, 32'd2,          32'h8000_0001, 0);
        run_op("div_zero",     0, 1, 0, 32'd5,          32'd0,         0);
        run_op("both_start",   1, 1, 0, 32'd6,          32'd3,         0);
        run_op("stray_start",  1, 0, 0, 32'd6,          32'd7,         5);
        run_op("div_overflow", 0, 1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 0);
        run_op("div_unsigned", 0, 1, 1, 32'hFFFF_FFFF,  32'd10,        0);
        run_op("mul_minmin",   1, 0, 0, 32'h8000_0000,  32'h8000_0000, 0);
        run_op("div_neg_both", 0, 1, 0, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 0);

        reset_mid_op();
        run_op("after_reset",  1, 0, 0, 32'd3,          32'd4,         0);

        for (int i = 0; i < 24; i++) begin
            rmul = $urandom_range(1);
            runs = $urandom_range(1);
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(7))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(15);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rmul, !rmul, runs, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
